// File: rtl/ctrl_unit.sv
// ctrl_unit: program counter / instruction register holder, instruction
// fetch sequencer and Moore decode FSM for the 6-instruction processor.
// Optional feature macro: SINGLE_STEP_EN (adds a Step input that gates FETCH).
module ctrl_unit #(
  parameter int PC_WIDTH  = 7,
  parameter int DATA_BITS = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
`ifdef SINGLE_STEP_EN
  input  logic                 Step,
`endif
  input  logic [DATA_BITS-1:0] IM_data,
  output logic [PC_WIDTH-1:0]  PC_Addr,
  output logic [7:0]           D_Addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic                 RF_W_en,
  output logic [3:0]           RF_W_addr,
  output logic [3:0]           RF_Ra_addr,
  output logic [3:0]           RF_Rb_addr,
  output logic [2:0]           ALU_s0,
  output logic [3:0]           State,
  output logic                 Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  state_t               state;
  state_t               next_state;
  logic [PC_WIDTH-1:0]  pc;
  logic [DATA_BITS-1:0] ir;
  logic [3:0]           opcode;
  logic                 fetch_go;

  assign opcode = ir[DATA_BITS-1 -: 4];

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_pend;
  logic step_rise;

  assign step_rise = Step & ~step_q;
  assign fetch_go  = step_pend | step_rise;

  // Remember a Step rising edge seen outside FETCH so it is not lost; consume it in FETCH
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= Step;
      if (state == S_FETCH)
        step_pend <= 1'b0;
      else if (step_rise)
        step_pend <= 1'b1;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // State, PC and IR registers; IR/PC only move on a granted FETCH cycle
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && fetch_go) begin
        ir <= IM_data;
        pc <= pc + PC_WIDTH'(1);
      end
    end
  end

  // Next-state logic: fixed sequencing plus opcode branch out of DECODE
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_STORE: next_state = S_STORE;
          OP_LOAD:  next_state = S_LOAD_A;
          OP_ADD:   next_state = S_ADD;
          OP_SUB:   next_state = S_SUB;
          OP_HALT:  next_state = S_HALT;
          default:  next_state = S_NOOP;
        endcase
      end
      S_LOAD_A: next_state = S_LOAD_B;
      S_LOAD_B: next_state = S_FETCH;
      S_STORE:  next_state = S_FETCH;
      S_ADD:    next_state = S_FETCH;
      S_SUB:    next_state = S_FETCH;
      S_NOOP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_INIT;
    endcase
  end

  // Moore datapath controls decoded from state and IR only; everything idles at 0
  always_comb begin
    D_Addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = 4'h0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = 3'b000;
    case (state)
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        D_Addr     = ir[7:0];
        RF_Ra_addr = ir[11:8];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        RF_W_addr  = ir[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

  assign PC_Addr = pc;
  assign State   = state;
  assign Halted  = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: table-driven, scoreboarded bench for ctrl_unit with a
// synchronous instruction ROM model.
module tb_ctrl_unit;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [15:0] IM_data = 16'h0000;
  logic [6:0]  PC_Addr;
  logic [7:0]  D_Addr;
  logic        D_wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;
`ifdef SINGLE_STEP_EN
  logic        Step = 1'b0;
`endif

  logic [15:0] rom [128];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic       w_en;
    logic [3:0] w_addr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    int          n_exec;
    outs_t       ex0;
    outs_t       ex1;
  } vec_t;

  vec_t  vecs [11];
  outs_t exp_q [$];

  ctrl_unit dut (
    .Clk(Clk), .ResetN(ResetN),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .IM_data(IM_data), .PC_Addr(PC_Addr), .D_Addr(D_Addr), .D_wr(D_wr),
    .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0),
    .State(State), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data appears one clock after the address
  always @(posedge Clk) IM_data <= rom[PC_Addr];

  function automatic outs_t mk(input logic [3:0] st, input logic [7:0] da, input logic dw,
                               input logic rs, input logic we, input logic [3:0] wa,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [2:0] alu, input logic h);
    outs_t o;
    o = '{st: st, pc: 7'd0, d_addr: da, d_wr: dw, rf_s: rs, w_en: we,
          w_addr: wa, ra: ra, rb: rb, alu: alu, halted: h};
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = '{st: State, pc: PC_Addr, d_addr: D_Addr, d_wr: D_wr, rf_s: RF_s, w_en: RF_W_en,
          w_addr: RF_W_addr, ra: RF_Ra_addr, rb: RF_Rb_addr, alu: ALU_s0, halted: Halted};
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Load one instruction into the ROM and queue its per-cycle expectations
  task automatic applyStimulus(input int k);
    outs_t e;
    rom[k] = vecs[k].instr;
    e = mk(4'd1, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0); e.pc = 7'(k);
    exp_q.push_back(e);
    e = mk(4'd2, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0); e.pc = 7'(k + 1);
    exp_q.push_back(e);
    e = vecs[k].ex0; e.pc = 7'(k + 1);
    exp_q.push_back(e);
    if (vecs[k].n_exec == 2) begin
      e = vecs[k].ex1; e.pc = 7'(k + 1);
      exp_q.push_back(e);
    end
    if (vecs[k].instr[15:12] == 4'h5) begin
      for (int j = 0; j < 19; j++) exp_q.push_back(e);
    end
  endtask

  task automatic runQueue();
    outs_t e;
    int n = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      checkOutput($sformatf("cycle%0d", n), e);
      n++;
    end
  endtask

  task automatic pulseReset();
    @(negedge Clk) ResetN = 1'b0;
    @(negedge Clk) ResetN = 1'b1;
  endtask

  initial begin
    outs_t zero;
    bit    seen;
    bit    any_en;
    zero = mk(4'd0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0);
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

    vecs[0]  = '{16'h2053, 2, mk(4'd4, 8'h05, 0, 1, 0, 4'h3, 4'h0, 4'h0, 3'b000, 0),
                              mk(4'd5, 8'h05, 0, 1, 1, 4'h3, 4'h0, 4'h0, 3'b000, 0)};
    vecs[1]  = '{16'h1309, 1, mk(4'd6, 8'h09, 1, 0, 0, 4'h0, 4'h3, 4'h0, 3'b000, 0), zero};
    vecs[2]  = '{16'h3124, 1, mk(4'd7, 8'h00, 0, 0, 1, 4'h4, 4'h1, 4'h2, 3'b001, 0), zero};
    vecs[3]  = '{16'h4124, 1, mk(4'd8, 8'h00, 0, 0, 1, 4'h4, 4'h1, 4'h2, 3'b010, 0), zero};
    vecs[4]  = '{16'h0000, 1, mk(4'd3, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0), zero};
    vecs[5]  = '{16'hF000, 1, mk(4'd3, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0), zero};
    vecs[6]  = '{16'h7ABC, 1, mk(4'd3, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0), zero};
    vecs[7]  = '{16'h2FF0, 2, mk(4'd4, 8'hFF, 0, 1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 0),
                              mk(4'd5, 8'hFF, 0, 1, 1, 4'h0, 4'h0, 4'h0, 3'b000, 0)};
    vecs[8]  = '{16'h1AFF, 1, mk(4'd6, 8'hFF, 1, 0, 0, 4'h0, 4'hA, 4'h0, 3'b000, 0), zero};
    vecs[9]  = '{16'h3FED, 1, mk(4'd7, 8'h00, 0, 0, 1, 4'hD, 4'hF, 4'hE, 3'b001, 0), zero};
    vecs[10] = '{16'h5000, 1, mk(4'd9, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1), zero};

    repeat (3) @(negedge Clk);
    checkOutput("reset_state", zero);

`ifdef SINGLE_STEP_EN
    @(negedge Clk) ResetN = 1'b1;
    repeat (10) @(negedge Clk);
    checkValue("step_hold_state", State, 1);
    checkValue("step_hold_pc", PC_Addr, 0);
    Step = 1'b1;
    repeat (10) @(negedge Clk);
    Step = 1'b0;
    checkValue("step_once_state", State, 1);
    checkValue("step_once_pc", PC_Addr, 1);
    repeat (5) @(negedge Clk);
    checkValue("step_released_pc", PC_Addr, 1);
`else
    // Main program: every cycle compared against the queued expectations
    for (int k = 0; k < 11; k++) applyStimulus(k);
    @(negedge Clk) ResetN = 1'b1;
    #1 checkOutput("init_after_release", zero);
    runQueue();

    // Reset out of HALT, then reset in the middle of a STORE
    rom[0] = 16'h1309;
    rom[1] = 16'h0000;
    @(negedge Clk) ResetN = 1'b0;
    #1 checkOutput("halt_reset", zero);
    @(negedge Clk) ResetN = 1'b1;
    @(negedge Clk) checkValue("restart_state", State, 1);
    checkValue("restart_pc", PC_Addr, 0);
    @(negedge Clk) checkValue("restart_decode", State, 2);
    @(negedge Clk) checkValue("store_dwr", D_wr, 1);
    ResetN = 1'b0;
    #1 checkValue("midstore_dwr", D_wr, 0);
    checkValue("midstore_state", State, 0);
    checkValue("midstore_pc", PC_Addr, 0);
    @(negedge Clk) ResetN = 1'b1;
    @(negedge Clk) checkValue("post_reset_fetch", State, 1);
    @(negedge Clk) checkValue("post_reset_decode", State, 2);

    // NOOP sweep through the whole ROM to exercise PC wrap
    for (int i = 0; i < 128; i++) rom[i] = (i % 2 == 0) ? 16'h0000 : 16'hF000;
    pulseReset();
    seen = 0;
    any_en = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge Clk);
      any_en = any_en | D_wr | RF_W_en | RF_s | Halted;
      if (State == 4'd1 && PC_Addr == 7'd127) seen = 1;
    end
    checkValue("wrap_reached_127", int'(seen), 1);
    @(negedge Clk);
    checkValue("wrap_decode_state", State, 2);
    checkValue("wrap_pc_zero", PC_Addr, 0);
    checkValue("noop_no_enables", int'(any_en), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
